cnt_hold_mod: RTL and testbench
===============================

Name: cnt_hold_mod

Overview:
- Parametrised modulo counter with optional hold-at-terminal and release-code wake-up.
- Generalises the fixed 0..2 display-phase counter: arbitrary width and terminal value, selectable hold or free-wrap mode, count enable, parallel load, and a registered wrap pulse for cascading.
- Optional hold timeout.
- Sits in the display/scan path, sequencing digit or phase selection from a code input.

Parameters:
WIDTH, 3, counter register width; must satisfy MAX < 2**WIDTH.
MAX, 2, terminal count value; the counter sequence is 0..MAX.
IN_W, 4, width of the release-code input.
REL_CODE, 3, value of `in` that releases the hold at MAX.
HOLD_MODE, 1, 1 = hold at MAX until release; 0 = free wrap MAX->0.
TIMEOUT, 16, enabled cycles spent in hold before forced release (macro only); must be >= 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, synchronous and active-high.
en  input  1  count enable; when low, all state is frozen.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value applied on load.
in  input  IN_W  release code, sampled only while holding.
cnt  output  WIDTH  current count (registered).
wrap  output  1  one-cycle pulse, registered, high in the first cycle cnt==0 after MAX->0.
holding  output  1  combinational: HOLD_MODE==1 && cnt==MAX.
timed_out  output  1  one-cycle pulse on forced release; tied 0 without the macro.

Behaviour:
- Priority order: rst > load > en.
- Reset (rst=1 at clk edge):
  - cnt=0, wrap=0, timed_out=0.
  - Internal hold timer=0.
  - Reset mid-hold or mid-count is immediate on that edge.
- Load (load=1):
  - cnt = min(load_val, MAX); values above MAX saturate to MAX.
  - wrap=0 and hold timer cleared.
  - Load occurs regardless of en.
  - Loading MAX with HOLD_MODE=1 enters hold next cycle.
- en=0, no load: cnt and hold timer unchanged; wrap=0, timed_out=0.
- en=1, cnt<MAX: cnt <= cnt+1, wrap=0.
- en=1, cnt==MAX, HOLD_MODE=0: cnt <= 0, wrap <= 1.
- en=1, cnt==MAX, HOLD_MODE=1:
  - If in==REL_CODE: cnt <= 0, wrap <= 1, hold timer cleared.
  - Otherwise cnt stays MAX, wrap=0, and the hold timer increments (macro only).
- Release code seen while cnt<MAX is ignored. It is not latched.
- Release takes effect on the same edge it is sampled; latency from `in` to cnt==0 is one clock.
- cnt never exceeds MAX; there is no other wrap-around path.
- Out-of-range cnt cannot arise, because load saturates.
- MAX=0 edge case:
  - HOLD_MODE=0: wrap is high every enabled cycle.
  - HOLD_MODE=1: permanently holding, released by code.

Optional Feature:
- Macro: CNT_HOLD_TIMEOUT_EN.
- Defined:
  - The hold timer (width clog2(TIMEOUT+1)) counts enabled cycles in hold.
  - When the timer equals TIMEOUT-1 and no release code is present, the next enabled edge forces cnt <= 0, wrap <= 1, timed_out <= 1, and clears the timer.
  - A release code on that same edge takes precedence: wrap=1, timed_out=0.
- Not defined: no timer logic; timed_out constant 0; hold lasts indefinitely.

Decomposition:
- Package cnt_pkg contains:
  - Mode constants CNT_MODE_FREE=0 and CNT_MODE_HOLD=1.
  - A clog2 constant function.
  - Elaboration check: MAX < 2**WIDTH.
- One natural sub-module, cnt_hold_timer:
  - Inputs: clk, rst, clr, inc.
  - Outputs: expire.
  - Instantiated only under CNT_HOLD_TIMEOUT_EN.

Test Plan:
- Default params, en=1, in=0, rst pulsed then released.
  - Required: cnt 0,1,2,2,2…; holding=1 from the first cnt==2; wrap never asserts.
- Holding at 2, drive in=3 for one cycle.
  - Required: next cycle cnt=0 and wrap=1 for exactly one cycle; then cnt=1.
- Drive in=3 while cnt=0 and cnt=1.
  - Required: ignored; cnt still reaches 2 and holds.
- HOLD_MODE=0, MAX=5, WIDTH=3.
  - Required: cnt 0..5,0…; wrap=1 only in each cycle cnt==0 following 5.
- load=1 with load_val=7, MAX=2 (same cycle as en=1): cnt=2, holding=1.
  - Assert rst mid-hold: next cycle cnt=0, wrap=0.
  - Toggle en=0 mid-count: cnt frozen.
- CNT_HOLD_TIMEOUT_EN, TIMEOUT=4, in=0.
  - Required: after 4 enabled hold cycles, cnt=0, wrap=1, timed_out=1.
  - in=3 on the expiry cycle gives timed_out=0.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and elaboration helpers for the cnt_hold_mod counter slice.
package cnt_pkg;

  localparam int unsigned CNT_MODE_FREE = 0;
  localparam int unsigned CNT_MODE_HOLD = 1;

  function automatic int unsigned cnt_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(v)) r = r + 1;
    return r;
  endfunction

  function automatic bit cnt_max_fits(input int unsigned width, input int unsigned max);
    return (width >= 32) || (longint'(max) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/cnt_hold_timer.sv
// Hold-duration timer: counts enabled hold cycles, flags the last cycle before forced release.
module cnt_hold_timer
  import cnt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int unsigned       TW   = cnt_clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]     LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (clr) begin
      tmr_d = '0;
    end else if (inc && (tmr_q != LAST)) begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign expire = (tmr_q == LAST);

endmodule

// File: rtl/cnt_hold_mod.sv
// Modulo 0..MAX counter with hold-at-terminal, release code, load and wrap pulse.
// Optional forced release after TIMEOUT hold cycles when CNT_HOLD_TIMEOUT_EN is defined.
module cnt_hold_mod
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX       = 2,
  parameter int unsigned IN_W      = 4,
  parameter int unsigned REL_CODE  = 3,
  parameter int unsigned HOLD_MODE = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [IN_W-1:0]  in,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             holding,
  output logic             timed_out
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [IN_W-1:0]  REL_V  = IN_W'(REL_CODE);
  localparam bit               HOLD_EN = (HOLD_MODE == CNT_MODE_HOLD);

  if (!cnt_max_fits(WIDTH, MAX)) begin : g_bad_cfg
    $error("cnt_hold_mod: MAX must be below 2**WIDTH");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max;
  logic             rel_hit;
  logic [WIDTH-1:0] load_sat;

  assign at_max   = (cnt_q == MAX_V);
  assign rel_hit  = (in == REL_V);
  assign load_sat = (load_val > MAX_V) ? MAX_V : load_val;

`ifdef CNT_HOLD_TIMEOUT_EN
  logic to_q, to_d;
  logic tmr_clr, tmr_inc, tmr_expire;

  cnt_hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .inc    (tmr_inc),
    .expire (tmr_expire)
  );
`endif

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
`ifdef CNT_HOLD_TIMEOUT_EN
    to_d    = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
`endif
    if (load) begin
      cnt_d = load_sat;
`ifdef CNT_HOLD_TIMEOUT_EN
      tmr_clr = 1'b1;
`endif
    end else if (en) begin
      if (!at_max) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else if (!HOLD_EN || rel_hit) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
`ifdef CNT_HOLD_TIMEOUT_EN
        tmr_clr = 1'b1;
`endif
      end
`ifdef CNT_HOLD_TIMEOUT_EN
      // Release code outranks expiry, so expiry is only reached without it.
      else if (tmr_expire) begin
        cnt_d   = '0;
        wrap_d  = 1'b1;
        to_d    = 1'b1;
        tmr_clr = 1'b1;
      end else begin
        tmr_inc = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
`ifdef CNT_HOLD_TIMEOUT_EN
      to_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
`ifdef CNT_HOLD_TIMEOUT_EN
      to_q   <= to_d;
`endif
    end
  end

  assign cnt     = cnt_q;
  assign wrap    = wrap_q;
  assign holding = HOLD_EN && at_max;
`ifdef CNT_HOLD_TIMEOUT_EN
  assign timed_out = to_q;
`else
  assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_hold_mod.sv
// Scoreboard bench for cnt_hold_mod: a hold-mode instance (MAX=2) and a free-wrap instance (MAX=5).
module tb_cnt_hold_mod;

`ifdef CNT_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int H_MAX = 2;
  localparam int F_MAX = 5;
  localparam int H_TO  = 4;
  localparam int REL   = 3;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [2:0] load_val;
  logic [3:0] in;

  logic [2:0] cnt_h, cnt_f;
  logic       wrap_h, wrap_f, hold_h, hold_f, to_h, to_f;

  always #5 clk = ~clk;

  cnt_hold_mod #(
    .WIDTH(3), .MAX(H_MAX), .IN_W(4), .REL_CODE(REL), .HOLD_MODE(1), .TIMEOUT(H_TO)
  ) dut_hold (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .in(in),
    .cnt(cnt_h), .wrap(wrap_h), .holding(hold_h), .timed_out(to_h)
  );

  cnt_hold_mod #(
    .WIDTH(3), .MAX(F_MAX), .IN_W(4), .REL_CODE(REL), .HOLD_MODE(0), .TIMEOUT(H_TO)
  ) dut_free (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .in(in),
    .cnt(cnt_f), .wrap(wrap_f), .holding(hold_f), .timed_out(to_f)
  );

  typedef struct {
    int cnt;
    bit wrap;
    bit to;
    int hold_cycles;
  } mstate_t;

  typedef struct {
    int cnt;
    bit wrap;
    bit holding;
    bit to;
  } exp_t;

  mstate_t ms_h, ms_f;
  exp_t    q_h[$];
  exp_t    q_f[$];
  int      checks = 0;
  int      errors = 0;

  // Reference behaviour written directly from the counter rules.
  function automatic mstate_t model_step(input mstate_t s, input int max, input bit hold_mode,
                                         input bit r, input bit e, input bit ld,
                                         input int lv, input int code);
    mstate_t n;
    n = s;
    n.wrap = 1'b0;
    n.to   = 1'b0;
    if (r) begin
      n.cnt = 0;
      n.hold_cycles = 0;
    end else if (ld) begin
      n.cnt = (lv > max) ? max : lv;
      n.hold_cycles = 0;
    end else if (e) begin
      if (s.cnt < max) begin
        n.cnt = s.cnt + 1;
      end else if (!hold_mode || code == REL) begin
        n.cnt = 0;
        n.wrap = 1'b1;
        n.hold_cycles = 0;
      end else if (TO_EN && (s.hold_cycles + 1 == H_TO)) begin
        n.cnt = 0;
        n.wrap = 1'b1;
        n.to = 1'b1;
        n.hold_cycles = 0;
      end else begin
        n.hold_cycles = s.hold_cycles + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t to_exp(input mstate_t s, input int max, input bit hold_mode);
    exp_t x;
    x.cnt = s.cnt;
    x.wrap = s.wrap;
    x.holding = hold_mode && (s.cnt == max);
    x.to = s.to;
    return x;
  endfunction

  task automatic step(input bit r, input bit e, input bit ld, input int lv, input int code);
    rst = r;
    en = e;
    load = ld;
    load_val = 3'(lv);
    in = 4'(code);
    ms_h = model_step(ms_h, H_MAX, 1'b1, r, e, ld, lv, code);
    ms_f = model_step(ms_f, F_MAX, 1'b0, r, e, ld, lv, code);
    @(posedge clk);
    q_h.push_back(to_exp(ms_h, H_MAX, 1'b1));
    q_f.push_back(to_exp(ms_f, F_MAX, 1'b0));
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_h.size() > 0) begin
      e = q_h.pop_front();
      checks = checks + 1;
      if (int'(cnt_h) != e.cnt || wrap_h !== e.wrap || hold_h !== e.holding || to_h !== e.to) begin
        errors = errors + 1;
        $display("FAIL hold_inst t=%0t: got cnt=%0d wrap=%b holding=%b timed_out=%b, want cnt=%0d wrap=%b holding=%b timed_out=%b",
                 $time, cnt_h, wrap_h, hold_h, to_h, e.cnt, e.wrap, e.holding, e.to);
      end
    end
    if (q_f.size() > 0) begin
      e = q_f.pop_front();
      checks = checks + 1;
      if (int'(cnt_f) != e.cnt || wrap_f !== e.wrap || hold_f !== e.holding || to_f !== e.to) begin
        errors = errors + 1;
        $display("FAIL free_inst t=%0t: got cnt=%0d wrap=%b holding=%b timed_out=%b, want cnt=%0d wrap=%b holding=%b timed_out=%b",
                 $time, cnt_f, wrap_f, hold_f, to_f, e.cnt, e.wrap, e.holding, e.to);
      end
    end
  end

  initial begin
    int code;
    ms_h = '{cnt: 0, wrap: 1'b0, to: 1'b0, hold_cycles: 0};
    ms_f = ms_h;
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; in = '0;
    #1;

    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, REL);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, REL);
    step(0, 1, 0, 0, REL);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 7, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, REL);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 6, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, REL);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 4, 0);

    for (int i = 0; i < 3000; i++) begin
      code = ($urandom_range(0, 3) == 0) ? REL : int'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 5, int'($urandom_range(0, 7)), code);
    end

    @(negedge clk);
    #1;
    if (q_h.size() != 0 || q_f.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q_h.size(), q_f.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
